// File: rtl/btb_assoc.sv
// ---------------------------------------------------------------------------
// btb_assoc -- set-associative branch target buffer with tree pseudo-LRU.
//
// The lookup is combinational on the fetch PC. Writes, invalidates, PLRU
// touches and flush all take effect at the rising edge of clk.
//
// Parameters:
//   SETS   number of sets (power of 2, 2..256)
//   WAYS   associativity (1, 2, 4 or 8)
//   TYPE_W width of the branch-type tag (0=cond, 1=jal, 2=jalr, 3=ret)
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pc_query, query_en  fetch PC; query_en lets a hit touch the PLRU state
//   hit, target_addr,   lookup result; target_addr and hit_type are 0 on miss
//   hit_type
//   update_en,          execute-stage write (update_inv=0) or invalidate
//   update_inv,         (update_inv=1) of the entry for pc_update
//   pc_update,
//   target_addr_update,
//   update_type
//   flush               clear every entry and all PLRU state
//
// Optional build macro BTB_ASSOC_BYPASS_EN: a same-cycle update to the
// queried PC is forwarded to the lookup outputs. Without it the lookup
// only ever reflects stored state.
// ---------------------------------------------------------------------------
module btb_assoc #(
  parameter int SETS   = 16,
  parameter int WAYS   = 2,
  parameter int TYPE_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc_query,
  input  logic              query_en,
  output logic              hit,
  output logic [31:0]       target_addr,
  output logic [TYPE_W-1:0] hit_type,
  input  logic              update_en,
  input  logic              update_inv,
  input  logic [31:0]       pc_update,
  input  logic [31:0]       target_addr_update,
  input  logic [TYPE_W-1:0] update_type,
  input  logic              flush
);

  localparam int IDX    = $clog2(SETS);
  localparam int TAG_W  = 30 - IDX;
  localparam int LVL    = (WAYS > 1) ? $clog2(WAYS) : 0;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

  // Valid bits and PLRU trees need a reset; the payload arrays do not.
  logic [WAYS-1:0]   validReg  [SETS];
  logic [PLRU_W-1:0] plruReg   [SETS];
  logic [TAG_W-1:0]  tagMem    [SETS][WAYS];
  logic [31:0]       targetMem [SETS][WAYS];
  logic [TYPE_W-1:0] typeMem   [SETS][WAYS];

  logic [IDX-1:0]   qIdx, uIdx;
  logic [TAG_W-1:0] qTag, uTag;
  assign qIdx = pc_query[IDX+1:2];
  assign qTag = pc_query[31:IDX+2];
  assign uIdx = pc_update[IDX+1:2];
  assign uTag = pc_update[31:IDX+2];

  // Byte-offset bits never take part in indexing or tagging.
  logic unusedBits;
  assign unusedBits = ^{pc_query[1:0], pc_update[1:0]};

  // PLRU tree stored heap-style: node n has children 2n+1 and 2n+2, the
  // leaves are the ways. A node bit of 0 points the victim to the left.
  function automatic logic [PLRU_W-1:0] plruTouch(input logic [PLRU_W-1:0] bits,
                                                  input logic [WAY_W-1:0]  way);
    logic [PLRU_W-1:0] res;
    int node;
    logic dir;
    res  = bits;
    node = 0;
    for (int l = 0; l < LVL; l++) begin
      dir       = way[LVL-1-l];
      res[node] = ~dir;                      // point away from the touched way
      node      = 2 * node + 1 + (dir ? 1 : 0);
    end
    return res;
  endfunction

  function automatic logic [WAY_W-1:0] plruVictim(input logic [PLRU_W-1:0] bits);
    logic [WAY_W-1:0] v;
    int node;
    logic dir;
    v    = '0;
    node = 0;
    for (int l = 0; l < LVL; l++) begin
      dir          = bits[node];
      v[LVL-1-l]   = dir;
      node         = 2 * node + 1 + (dir ? 1 : 0);
    end
    return v;
  endfunction

  // Per-way tag comparison for both the lookup port and the update port.
  logic [WAYS-1:0] qMatch, uMatch;
  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : gWayCmp
      assign qMatch[gi] = validReg[qIdx][gi] && (tagMem[qIdx][gi] == qTag);
      assign uMatch[gi] = validReg[uIdx][gi] && (tagMem[uIdx][gi] == uTag);
    end
  endgenerate

  logic             qHit, uHit, uFree;
  logic [WAY_W-1:0] qWay, uWay, freeWay, victimWay, allocWay;

  // Updates never create a duplicate tag in a set, so these are one-hot
  // and a plain index encode is enough.
  always_comb begin
    qHit    = |qMatch;
    uHit    = |uMatch;
    uFree   = ~&validReg[uIdx];
    qWay    = '0;
    uWay    = '0;
    freeWay = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (qMatch[w]) qWay = WAY_W'(w);
      if (uMatch[w]) uWay = WAY_W'(w);
    end
    // Walk downwards so the lowest-index invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!validReg[uIdx][w]) freeWay = WAY_W'(w);
    end
    victimWay = (WAYS > 1) ? plruVictim(plruReg[uIdx]) : '0;
    if (uHit)       allocWay = uWay;
    else if (uFree) allocWay = freeWay;
    else            allocWay = victimWay;
  end

  logic              queryTouch, updWrite, updInv;
  logic [PLRU_W-1:0] qTouched, uBase, uTouched;

  assign queryTouch = query_en && qHit;
  assign updWrite   = update_en && !update_inv;
  assign updInv     = update_en && update_inv && uHit;

  // Same-set touch ordering: the query touch is applied first, then the
  // update touch on top of it, so the updated way ends up MRU.
  assign qTouched = plruTouch(plruReg[qIdx], qWay);
  assign uBase    = (queryTouch && (qIdx == uIdx)) ? qTouched : plruReg[uIdx];
  assign uTouched = plruTouch(uBase, allocWay);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int s = 0; s < SETS; s++) begin
        validReg[s] <= '0;
        plruReg[s]  <= '0;
      end
    end else begin
      if (queryTouch) plruReg[qIdx] <= qTouched;
      if (updWrite) begin
        validReg[uIdx][allocWay] <= 1'b1;
        plruReg[uIdx]            <= uTouched;   // later assignment wins on same set
      end else if (updInv) begin
        validReg[uIdx][uWay] <= 1'b0;           // PLRU deliberately left alone
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && updWrite) begin
      tagMem[uIdx][allocWay]    <= uTag;
      targetMem[uIdx][allocWay] <= target_addr_update;
      typeMem[uIdx][allocWay]   <= update_type;
    end
  end

  logic [31:0]       storedTarget;
  logic [TYPE_W-1:0] storedType;
  assign storedTarget = qHit ? targetMem[qIdx][qWay] : 32'd0;
  assign storedType   = qHit ? typeMem[qIdx][qWay]   : '0;

`ifdef BTB_ASSOC_BYPASS_EN
  always_comb begin
    hit         = qHit;
    target_addr = storedTarget;
    hit_type    = storedType;
    if (flush) begin
      hit         = 1'b0;
      target_addr = 32'd0;
      hit_type    = '0;
    end else if (update_en && (pc_update == pc_query)) begin
      if (update_inv) begin
        hit         = 1'b0;
        target_addr = 32'd0;
        hit_type    = '0;
      end else begin
        hit         = 1'b1;
        target_addr = target_addr_update;
        hit_type    = update_type;
      end
    end
  end
`else
  assign hit         = qHit;
  assign target_addr = storedTarget;
  assign hit_type    = storedType;
`endif

endmodule

// File: tb/tb_btb_assoc.sv
// ---------------------------------------------------------------------------
// tb_btb_assoc -- directed self-checking bench for btb_assoc (SETS=16,
// WAYS=2). 0x80000010, 0x80000050 and 0x80000090 share set 4.
// ---------------------------------------------------------------------------
module tb_btb_assoc;

  logic        clk;
  logic        rst;
  logic [31:0] pc_query;
  logic        query_en;
  logic        hit;
  logic [31:0] target_addr;
  logic [1:0]  hit_type;
  logic        update_en;
  logic        update_inv;
  logic [31:0] pc_update;
  logic [31:0] target_addr_update;
  logic [1:0]  update_type;
  logic        flush;

  int passCnt  = 0;
  int totalCnt = 0;

  btb_assoc #(.SETS(16), .WAYS(2), .TYPE_W(2)) dut (
    .clk                (clk),
    .rst                (rst),
    .pc_query           (pc_query),
    .query_en           (query_en),
    .hit                (hit),
    .target_addr        (target_addr),
    .hit_type           (hit_type),
    .update_en          (update_en),
    .update_inv         (update_inv),
    .pc_update          (pc_update),
    .target_addr_update (target_addr_update),
    .update_type        (update_type),
    .flush              (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // Align to 1 time unit after a rising edge.
  task automatic syncEdge();
    @(posedge clk);
    #1;
  endtask

  // One-cycle write/invalidate request.
  task automatic doUpdate(input logic [31:0] pc, input logic [31:0] tgt,
                          input logic [1:0] ty, input logic inv);
    update_en          = 1'b1;
    update_inv         = inv;
    pc_update          = pc;
    target_addr_update = tgt;
    update_type        = ty;
    syncEdge();
    update_en  = 1'b0;
    update_inv = 1'b0;
    $display("update pc=%h tgt=%h type=%0d inv=%0b", pc, tgt, ty, inv);
  endtask

  task automatic test_reset();
    logic [34:0] got, exp;
    rst = 1'b1;
    syncEdge();
    syncEdge();
    rst = 1'b0;
    pc_query = 32'h80000010;
    #1;
    got = {hit, target_addr, hit_type};
    exp = {1'b0, 32'h0, 2'd0};
    totalCnt++;
    $display("query pc=%h hit=%0b tgt=%h type=%0d", pc_query, hit, target_addr, hit_type);
    if (got !== exp) $display("FAIL reset_query: got %h required %h", got, exp);
    else passCnt++;
  endtask

  task automatic test_update();
    logic [34:0] got, exp;
    syncEdge();
    doUpdate(32'h80000010, 32'h80000100, 2'd0, 1'b0);
    pc_query = 32'h80000010;
    #1;
    got = {hit, target_addr, hit_type};
    exp = {1'b1, 32'h80000100, 2'd0};
    totalCnt++;
    $display("query pc=%h hit=%0b tgt=%h type=%0d", pc_query, hit, target_addr, hit_type);
    if (got !== exp) $display("FAIL first_write: got %h required %h", got, exp);
    else passCnt++;
    syncEdge();
    doUpdate(32'h80000010, 32'h80000200, 2'd2, 1'b0);
    #1;
    got = {hit, target_addr, hit_type};
    exp = {1'b1, 32'h80000200, 2'd2};
    totalCnt++;
    $display("query pc=%h hit=%0b tgt=%h type=%0d", pc_query, hit, target_addr, hit_type);
    if (got !== exp) $display("FAIL overwrite: got %h required %h", got, exp);
    else passCnt++;
  endtask

  // Way0=0x10, way1=0x50; touch way0 via query; 0x90 must evict way1.
  task automatic test_plru();
    logic [31:0] pcs  [5];
    logic [34:0] exps [5];
    logic [34:0] got;
    syncEdge();
    doUpdate(32'h80000010, 32'h80000100, 2'd1, 1'b0);
    doUpdate(32'h80000050, 32'h80000500, 2'd3, 1'b0);
    pcs[0] = 32'h80000050; exps[0] = {1'b1, 32'h80000500, 2'd3};
    pcs[1] = 32'h80000010; exps[1] = {1'b1, 32'h80000100, 2'd1};
    for (int i = 0; i < 2; i++) begin
      pc_query = pcs[i];
      #1;
      got = {hit, target_addr, hit_type};
      totalCnt++;
      $display("query pc=%h hit=%0b tgt=%h type=%0d", pc_query, hit, target_addr, hit_type);
      if (got !== exps[i]) $display("FAIL set_fill_%0d: got %h required %h", i, got, exps[i]);
      else passCnt++;
    end
    syncEdge();
    pc_query = 32'h80000010;
    query_en = 1'b1;
    syncEdge();
    query_en = 1'b0;
    $display("touch pc=%h", pc_query);
    doUpdate(32'h80000090, 32'h80000900, 2'd2, 1'b0);
    pcs[2] = 32'h80000050; exps[2] = {1'b0, 32'h0, 2'd0};
    pcs[3] = 32'h80000010; exps[3] = {1'b1, 32'h80000100, 2'd1};
    pcs[4] = 32'h80000090; exps[4] = {1'b1, 32'h80000900, 2'd2};
    for (int i = 2; i < 5; i++) begin
      pc_query = pcs[i];
      #1;
      got = {hit, target_addr, hit_type};
      totalCnt++;
      $display("query pc=%h hit=%0b tgt=%h type=%0d", pc_query, hit, target_addr, hit_type);
      if (got !== exps[i]) $display("FAIL plru_evict_%0d: got %h required %h", i, got, exps[i]);
      else passCnt++;
    end
  endtask

  task automatic test_invalidate();
    logic [31:0] pcs  [5];
    logic [34:0] exps [5];
    logic [34:0] got;
    syncEdge();
    doUpdate(32'h80000010, 32'h0, 2'd0, 1'b1);
    pcs[0] = 32'h80000010; exps[0] = {1'b0, 32'h0, 2'd0};
    pcs[1] = 32'h80000090; exps[1] = {1'b1, 32'h80000900, 2'd2};
    for (int i = 0; i < 2; i++) begin
      pc_query = pcs[i];
      #1;
      got = {hit, target_addr, hit_type};
      totalCnt++;
      $display("query pc=%h hit=%0b tgt=%h type=%0d", pc_query, hit, target_addr, hit_type);
      if (got !== exps[i]) $display("FAIL inv_hit_%0d: got %h required %h", i, got, exps[i]);
      else passCnt++;
    end
    syncEdge();
    doUpdate(32'h80000400, 32'h0, 2'd0, 1'b1);
    // Freed way0 is reused, so 0x90 in way1 survives.
    doUpdate(32'h80000050, 32'h80000550, 2'd0, 1'b0);
    pcs[2] = 32'h80000090; exps[2] = {1'b1, 32'h80000900, 2'd2};
    pcs[3] = 32'h80000050; exps[3] = {1'b1, 32'h80000550, 2'd0};
    pcs[4] = 32'h80000400; exps[4] = {1'b0, 32'h0, 2'd0};
    for (int i = 2; i < 5; i++) begin
      pc_query = pcs[i];
      #1;
      got = {hit, target_addr, hit_type};
      totalCnt++;
      $display("query pc=%h hit=%0b tgt=%h type=%0d", pc_query, hit, target_addr, hit_type);
      if (got !== exps[i]) $display("FAIL inv_miss_%0d: got %h required %h", i, got, exps[i]);
      else passCnt++;
    end
  endtask

  // Back-to-back updates into sets 0..3, then flush with a concurrent update.
  task automatic test_back_to_back_flush();
    logic [31:0] pcs [6];
    logic [34:0] got, exp;
    pcs[0] = 32'h80000000; pcs[1] = 32'h80000004;
    pcs[2] = 32'h80000008; pcs[3] = 32'h8000000C;
    pcs[4] = 32'h80000020; pcs[5] = 32'h80000090;
    syncEdge();
    for (int i = 0; i < 4; i++) doUpdate(pcs[i], 32'h90000000 + 32'(i * 16), 2'(i), 1'b0);
    for (int i = 0; i < 4; i++) begin
      pc_query = pcs[i];
      #1;
      got = {hit, target_addr, hit_type};
      exp = {1'b1, 32'h90000000 + 32'(i * 16), 2'(i)};
      totalCnt++;
      $display("query pc=%h hit=%0b tgt=%h type=%0d", pc_query, hit, target_addr, hit_type);
      if (got !== exp) $display("FAIL b2b_%0d: got %h required %h", i, got, exp);
      else passCnt++;
    end
    syncEdge();
    flush = 1'b1;
    doUpdate(32'h80000020, 32'h80000220, 2'd1, 1'b0);
    flush = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pc_query = pcs[i];
      #1;
      got = {hit, target_addr, hit_type};
      exp = {1'b0, 32'h0, 2'd0};
      totalCnt++;
      $display("query pc=%h hit=%0b tgt=%h type=%0d", pc_query, hit, target_addr, hit_type);
      if (got !== exp) $display("FAIL flush_%0d: got %h required %h", i, got, exp);
      else passCnt++;
    end
  endtask

  task automatic test_same_cycle();
    logic [34:0] got, exp;
    syncEdge();
    pc_query           = 32'h80000030;
    update_en          = 1'b1;
    update_inv         = 1'b0;
    pc_update          = 32'h80000030;
    target_addr_update = 32'h80000300;
    update_type        = 2'd1;
    #1;
    got = {hit, target_addr, hit_type};
`ifdef BTB_ASSOC_BYPASS_EN
    exp = {1'b1, 32'h80000300, 2'd1};
`else
    exp = {1'b0, 32'h0, 2'd0};
`endif
    totalCnt++;
    $display("query pc=%h hit=%0b tgt=%h type=%0d (same-cycle update)", pc_query, hit, target_addr, hit_type);
    if (got !== exp) $display("FAIL same_cycle: got %h required %h", got, exp);
    else passCnt++;
    syncEdge();
    update_en = 1'b0;
    #1;
    got = {hit, target_addr, hit_type};
    exp = {1'b1, 32'h80000300, 2'd1};
    totalCnt++;
    $display("query pc=%h hit=%0b tgt=%h type=%0d", pc_query, hit, target_addr, hit_type);
    if (got !== exp) $display("FAIL next_cycle: got %h required %h", got, exp);
    else passCnt++;
  endtask

  initial begin
    rst                = 1'b1;
    pc_query           = 32'h0;
    query_en           = 1'b0;
    update_en          = 1'b0;
    update_inv         = 1'b0;
    pc_update          = 32'h0;
    target_addr_update = 32'h0;
    update_type        = 2'd0;
    flush              = 1'b0;
    test_reset();
    test_update();
    test_plru();
    test_invalidate();
    test_back_to_back_flush();
    test_same_cycle();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
